// File: rtl/mmcm_reset_sequencer.sv
// Staged reset release for the core once the MMCM has locked and stayed locked.
// Re-asserts every stage on lock loss or software request; counts lock losses.
module mmcm_reset_sequencer #(
  parameter int SYNC_STAGES        = 2,
  parameter int LOCK_STABLE_CYCLES = 256,
  parameter int STAGE_GAP_CYCLES   = 16,
  parameter int NUM_STAGES         = 3,
  parameter int LOSS_CNT_W         = 8
) (
  input  logic                  CLK,
  input  logic                  ASYNC_RESET_N,
  input  logic                  LOCKED,
  input  logic                  SW_RESET,
  output logic [NUM_STAGES-1:0] RESET_OUT_N,
  output logic                  READY,
  output logic [LOSS_CNT_W-1:0] LOCK_LOSS_COUNT,
  output logic [1:0]            STATE
);

  localparam int SCW = $clog2(LOCK_STABLE_CYCLES + 1);
  localparam int GCW = $clog2(STAGE_GAP_CYCLES + 1);
  localparam logic [SCW-1:0] SC_ONE = SCW'(1);
  localparam logic [SCW-1:0] SC_MAX = SCW'(LOCK_STABLE_CYCLES);
  localparam logic [GCW-1:0] GC_MAX = GCW'(STAGE_GAP_CYCLES);

  if (SYNC_STAGES < 2) begin : g_chk_sync
    $error("SYNC_STAGES must be >= 2");
  end
  if (LOCK_STABLE_CYCLES < 1) begin : g_chk_stable
    $error("LOCK_STABLE_CYCLES must be >= 1");
  end
  if (STAGE_GAP_CYCLES < 1) begin : g_chk_gap
    $error("STAGE_GAP_CYCLES must be >= 1");
  end
  if (NUM_STAGES < 1) begin : g_chk_stages
    $error("NUM_STAGES must be >= 1");
  end
  if (LOSS_CNT_W < 1) begin : g_chk_loss
    $error("LOSS_CNT_W must be >= 1");
  end

  typedef enum logic [1:0] {
    S_WAIT_LOCK = 2'd0,
    S_STABLE    = 2'd1,
    S_RELEASE   = 2'd2,
    S_RUN       = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic [SYNC_STAGES-1:0]  sync_q, sync_d;
  logic [SCW-1:0]          scnt_q, scnt_d;
  logic [GCW-1:0]          gcnt_q, gcnt_d;
  logic [NUM_STAGES-1:0]   rst_q, rst_d;
  logic                    ready_q, ready_d;
  logic [LOSS_CNT_W-1:0]   loss_q, loss_d;
  logic [NUM_STAGES-1:0]   therm;
  logic                    lock_s;
  logic                    first_rel;

  assign sync_d = {sync_q[SYNC_STAGES-2:0], LOCKED};
  assign lock_s = sync_q[SYNC_STAGES-1];

  // Next release pattern: one more stage shifted in from bit 0 upward.
  always_comb begin
    therm    = '0;
    therm[0] = 1'b1;
    for (int i = 1; i < NUM_STAGES; i++) therm[i] = rst_q[i-1];
  end

  always_comb begin
    state_d   = state_q;
    scnt_d    = scnt_q;
    gcnt_d    = gcnt_q;
    rst_d     = rst_q;
    ready_d   = ready_q;
    loss_d    = loss_q;
    first_rel = 1'b0;
    case (state_q)
      S_WAIT_LOCK: begin
        rst_d   = '0;
        ready_d = 1'b0;
        scnt_d  = '0;
        if (lock_s) begin
          scnt_d = SC_ONE;
          if (SC_ONE == SC_MAX) first_rel = 1'b1;
          else                  state_d   = S_STABLE;
        end
      end
      S_STABLE: begin
        if (!lock_s) begin
          state_d = S_WAIT_LOCK;
          scnt_d  = '0;
        end else begin
          scnt_d = scnt_q + 1'b1;
          if (scnt_d == SC_MAX) first_rel = 1'b1;
        end
      end
      S_RELEASE, S_RUN: begin
        if (!lock_s) begin
          state_d = S_WAIT_LOCK;
          rst_d   = '0;
          ready_d = 1'b0;
          scnt_d  = '0;
          if (loss_q != '1) loss_d = loss_q + 1'b1;
        end else if (SW_RESET) begin
          // Software restart requalifies lock from scratch but is not a loss.
          state_d = S_STABLE;
          rst_d   = '0;
          ready_d = 1'b0;
          scnt_d  = '0;
        end else if (state_q == S_RELEASE) begin
          gcnt_d = gcnt_q + 1'b1;
          if (gcnt_d == GC_MAX) begin
            gcnt_d = '0;
            rst_d  = therm;
            if (&therm) begin
              state_d = S_RUN;
              ready_d = 1'b1;
            end
          end
        end
      end
      default: state_d = S_WAIT_LOCK;
    endcase

    if (first_rel) begin
      rst_d  = NUM_STAGES'(1);
      gcnt_d = '0;
      if (NUM_STAGES == 1) begin
        state_d = S_RUN;
        ready_d = 1'b1;
      end else begin
        state_d = S_RELEASE;
      end
    end
  end

  always_ff @(posedge CLK or negedge ASYNC_RESET_N) begin
    if (!ASYNC_RESET_N) begin
      state_q <= S_WAIT_LOCK;
      sync_q  <= '0;
      scnt_q  <= '0;
      gcnt_q  <= '0;
      rst_q   <= '0;
      ready_q <= 1'b0;
      loss_q  <= '0;
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      scnt_q  <= scnt_d;
      gcnt_q  <= gcnt_d;
      rst_q   <= rst_d;
      ready_q <= ready_d;
      loss_q  <= loss_d;
    end
  end

  assign RESET_OUT_N     = rst_q;
  assign READY           = ready_q;
  assign LOCK_LOSS_COUNT = loss_q;
  assign STATE           = state_q;

endmodule
